// File: rtl/lvds_link_pkg.sv
// Shared definitions for the LVDS link training controller: FSM encodings,
// the training word and the slip-count width.
package lvds_link_pkg;

  localparam int SLIP_W = 3;

  // Chosen so that no rotation of the word equals the word itself.
  localparam logic [23:0] TRAIN_WORD = 24'hA5C396;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_ALIGN     = 3'd2,
    ST_LINK_UP   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } top_state_e;

  typedef enum logic [1:0] {
    LN_SETTLE = 2'd0,
    LN_CHECK  = 2'd1,
    LN_DONE   = 2'd2,
    LN_FAIL   = 2'd3
  } lane_state_e;

endpackage

// File: rtl/lvds_link_train_ctrl_if.sv
// Signal bundle between the link training controller and the TX/RX wrappers.
interface lvds_link_train_ctrl_if;
  import lvds_link_pkg::*;

  logic              I_pll_lock_o;
  logic              I_pll_lock_e;
  logic [23:0]       I_rx_rgb_o;
  logic [23:0]       I_rx_rgb_e;
  logic              I_err_o;
  logic              I_err_e;
  logic              I_retrain;
  logic              O_tx_train;
  logic              O_bitslip_o;
  logic              O_bitslip_e;
  logic [SLIP_W-1:0] O_slip_cnt_o;
  logic [SLIP_W-1:0] O_slip_cnt_e;
  logic              O_link_up;
  logic              O_train_fail;
  logic [2:0]        O_state;

  modport master (
    output I_pll_lock_o, I_pll_lock_e, I_rx_rgb_o, I_rx_rgb_e, I_err_o, I_err_e, I_retrain,
    input  O_tx_train, O_bitslip_o, O_bitslip_e, O_slip_cnt_o, O_slip_cnt_e,
           O_link_up, O_train_fail, O_state
  );

  modport slave (
    input  I_pll_lock_o, I_pll_lock_e, I_rx_rgb_o, I_rx_rgb_e, I_err_o, I_err_e, I_retrain,
    output O_tx_train, O_bitslip_o, O_bitslip_e, O_slip_cnt_o, O_slip_cnt_e,
           O_link_up, O_train_fail, O_state
  );

endinterface

// File: rtl/lvds_lane_align.sv
// Per-channel word aligner: settle, look for a run of training words, and
// bitslip the deserialiser on a mismatch until the slip budget runs out.
module lvds_lane_align
  import lvds_link_pkg::*;
#(
  parameter int SETTLE    = 16,
  parameter int MATCH_CNT = 64,
  parameter int MAX_SLIP  = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [23:0]       rx_i,
  output logic              bitslip_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [SLIP_W-1:0] slip_cnt_o
);

  localparam int ST_W = $clog2(SETTLE) + 1;
  localparam int MC_W = $clog2(MATCH_CNT) + 1;
  localparam logic [ST_W-1:0]   SETTLE_LAST = ST_W'(SETTLE - 1);
  localparam logic [MC_W-1:0]   MATCH_LAST  = MC_W'(MATCH_CNT - 1);
  localparam logic [SLIP_W-1:0] SLIP_LAST   = SLIP_W'(MAX_SLIP - 1);

  lane_state_e       state_q, state_d;
  logic [ST_W-1:0]   settle_q, settle_d;
  logic [MC_W-1:0]   match_q, match_d;
  logic [SLIP_W-1:0] slip_q, slip_d;
  logic              bitslip_q, bitslip_d;
  logic              start_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= LN_SETTLE;
      settle_q  <= '0;
      match_q   <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      bitslip_q <= bitslip_d;
      start_q   <= start_i;
    end
  end

  // start_i is a level; its rising edge restarts the lane, low freezes it.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    match_d   = match_q;
    slip_d    = slip_q;
    bitslip_d = 1'b0;
    if (start_i && !start_q) begin
      state_d  = LN_SETTLE;
      settle_d = '0;
      match_d  = '0;
      slip_d   = '0;
    end else if (start_i) begin
      case (state_q)
        LN_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = LN_CHECK;
            settle_d = '0;
            match_d  = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        LN_CHECK: begin
          if (rx_i == TRAIN_WORD) begin
            if (match_q == MATCH_LAST) state_d = LN_DONE;
            else                       match_d = match_q + 1'b1;
          end else if (slip_q < SLIP_LAST) begin
            bitslip_d = 1'b1;
            slip_d    = slip_q + 1'b1;
            match_d   = '0;
            settle_d  = '0;
            state_d   = LN_SETTLE;
          end else begin
            state_d = LN_FAIL;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign bitslip_o  = bitslip_q;
  assign done_o     = (state_q == LN_DONE);
  assign fail_o     = (state_q == LN_FAIL);
  assign slip_cnt_o = slip_q;

endmodule

// File: rtl/lvds_link_train_ctrl.sv
// Top-level LVDS link bring-up: PLL lock qualification, per-lane alignment,
// link-up supervision and retraining on lock loss, errors or request.
module lvds_link_train_ctrl
  import lvds_link_pkg::*;
#(
  parameter int LOCK_WAIT = 1024,
  parameter int SETTLE    = 16,
  parameter int MATCH_CNT = 64,
  parameter int MAX_SLIP  = 7,
  parameter int ERR_LIMIT = 4
) (
  input logic                   I_clk,
  input logic                   I_rst,
  lvds_link_train_ctrl_if.slave bus
);

  localparam int LW_W = $clog2(LOCK_WAIT) + 1;
  localparam int ER_W = $clog2(ERR_LIMIT) + 1;
  localparam logic [LW_W-1:0] LOCK_LAST = LW_W'(LOCK_WAIT - 1);
  localparam logic [ER_W-1:0] ERR_LAST  = ER_W'(ERR_LIMIT - 1);

  top_state_e      state_q, state_d;
  logic [LW_W-1:0] wait_q, wait_d;
  logic [ER_W-1:0] err_q, err_d;
  logic            train_fail_q, train_fail_d;
  logic            tx_train_q, link_up_q;
  logic            lock_ok, lane_run;

  logic [23:0]       rx_w      [2];
  logic              bitslip_w [2];
  logic              done_w    [2];
  logic              fail_w    [2];
  logic [SLIP_W-1:0] slip_w    [2];

  assign lock_ok  = bus.I_pll_lock_o & bus.I_pll_lock_e;
  assign lane_run = (state_d == ST_ALIGN);
  assign rx_w[0]  = bus.I_rx_rgb_o;
  assign rx_w[1]  = bus.I_rx_rgb_e;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      lvds_lane_align #(
        .SETTLE    (SETTLE),
        .MATCH_CNT (MATCH_CNT),
        .MAX_SLIP  (MAX_SLIP)
      ) u_lane (
        .clk_i      (I_clk),
        .rst_i      (I_rst),
        .start_i    (lane_run),
        .rx_i       (rx_w[gi]),
        .bitslip_o  (bitslip_w[gi]),
        .done_o     (done_w[gi]),
        .fail_o     (fail_w[gi]),
        .slip_cnt_o (slip_w[gi])
      );
    end
  endgenerate

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      err_q        <= '0;
      train_fail_q <= 1'b0;
      tx_train_q   <= 1'b0;
      link_up_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
      train_fail_q <= train_fail_d;
      tx_train_q   <= (state_d == ST_WAIT_LOCK) || (state_d == ST_ALIGN) ||
                      (state_d == ST_HOLDOFF);
      link_up_q    <= (state_d == ST_LINK_UP);
    end
  end

  // Lock loss overrides everything; in ALIGN a lane failure beats completion.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    train_fail_d = train_fail_q;
    if (state_q != ST_IDLE && !lock_ok) begin
      state_d = ST_WAIT_LOCK;
      wait_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_LOCK;
          wait_d  = '0;
        end
        ST_WAIT_LOCK, ST_HOLDOFF: begin
          if (wait_q == LOCK_LAST) begin
            state_d = ST_ALIGN;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        ST_ALIGN: begin
          if (fail_w[0] || fail_w[1]) begin
            state_d      = ST_HOLDOFF;
            train_fail_d = 1'b1;
            wait_d       = '0;
          end else if (done_w[0] && done_w[1]) begin
            state_d      = ST_LINK_UP;
            train_fail_d = 1'b0;
            err_d        = '0;
          end
        end
        ST_LINK_UP: begin
          if (bus.I_retrain) begin
            state_d = ST_ALIGN;
          end else if (bus.I_err_o || bus.I_err_e) begin
            if (err_q == ERR_LAST) state_d = ST_ALIGN;
            else                   err_d   = err_q + 1'b1;
          end else begin
            err_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.O_state      = state_q;
  assign bus.O_tx_train   = tx_train_q;
  assign bus.O_link_up    = link_up_q;
  assign bus.O_train_fail = train_fail_q;
  assign bus.O_bitslip_o  = bitslip_w[0];
  assign bus.O_bitslip_e  = bitslip_w[1];
  assign bus.O_slip_cnt_o = slip_w[0];
  assign bus.O_slip_cnt_e = slip_w[1];

endmodule
